// File: rtl/read_slave_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// read_slave_scheduler_pkg
//   Shared types and helpers for the read-only crossbar slave schedulers.
//   - state_e     : scheduler FSM states.
//   - clog2_min1  : index width, never below one bit.
//   - rr_pick     : round-robin search (first set request from ptr upward,
//                   modulo n). Works on a fixed-width vector so any port count
//                   up to RR_MAX_W can share the same function.
// -----------------------------------------------------------------------------
package read_slave_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR      = 2'd1,
        WAIT_RESP = 2'd2
    } state_e;

    localparam int RR_MAX_W = 32;
    localparam int RR_IDX_W = 5;

    typedef struct packed {
        logic                valid;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // ptr must be < n and n <= RR_MAX_W. Candidate j = (ptr + k) mod n; the
    // first hit wins, so the search starts at ptr and wraps once.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_W-1:0] req,
                                         input int                  ptr,
                                         input int                  n);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = 0; k < RR_MAX_W; k++) begin
            j = ptr + k;
            if (j >= n) j = j - n;
            if ((k < n) && !r.valid && req[j[RR_IDX_W-1:0]]) begin
                r.valid = 1'b1;
                r.idx   = j[RR_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/read_slave_scheduler_rr_pick_comb.sv
// -----------------------------------------------------------------------------
// read_slave_scheduler_rr_pick_comb
//   Combinational round-robin priority picker, NUM_PORTS wide.
//   Ports:
//     i_req     requests to choose from
//     i_ptr     index where the search starts (highest priority)
//     o_valid   at least one request set
//     o_idx     binary index of the winner
//     o_onehot  one-hot winner, zero when o_valid is low
// -----------------------------------------------------------------------------
module read_slave_scheduler_rr_pick_comb
    import read_slave_scheduler_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic                 o_valid,
    output logic [IDX_W-1:0]     o_idx,
    output logic [NUM_PORTS-1:0] o_onehot
);

    rr_pick_t w_pick;

    always_comb begin
        w_pick   = rr_pick(RR_MAX_W'(i_req), int'(i_ptr), NUM_PORTS);
        o_valid  = w_pick.valid;
        o_idx    = IDX_W'(w_pick.idx);
        o_onehot = w_pick.valid ? (NUM_PORTS'(1) << IDX_W'(w_pick.idx)) : '0;
    end

endmodule

// File: rtl/read_slave_scheduler.sv
// -----------------------------------------------------------------------------
// read_slave_scheduler
//   Shares one slave read port between NUM_PORTS masters. Ownership is locked
//   from grant until the slave's read response returns, so the crossbar can
//   route rdata back with grant_o. Round-robin between owners, at most
//   MAX_HOLD back-to-back transactions per owner while others wait, and a
//   forced release when no response arrives within TIMEOUT cycles.
//   Ports:
//     clk             clock, rising edge
//     reset           asynchronous, active-low reset
//     req_i           per-master level request
//     slave_gnt_i     slave accepted the owner's address this cycle
//     slave_rvalid_i  slave read data valid this cycle
//     grant_o         one-hot owner (registered), crossbar select
//     grant_idx_o     binary owner index
//     active_o        any grant set
//     timeout_o       one-cycle pulse in the cycle the response timer expires
// -----------------------------------------------------------------------------
module read_slave_scheduler
    import read_slave_scheduler_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    parameter  int MAX_HOLD  = 4,
    parameter  int TIMEOUT   = 16,
    localparam int IDX_W     = clog2_min1(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 slave_gnt_i,
    input  logic                 slave_rvalid_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [IDX_W-1:0]     grant_idx_o,
    output logic                 active_o,
    output logic                 timeout_o
);

    localparam int               HOLD_W     = clog2_min1(MAX_HOLD);
    localparam int               TIMER_W    = clog2_min1(TIMEOUT);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_PORTS - 1);

    state_e               r_state, w_state_nxt;
    logic [NUM_PORTS-1:0] r_grant, w_grant_nxt;
    logic [IDX_W-1:0]     r_idx,   w_idx_nxt;
    logic [IDX_W-1:0]     r_ptr,   w_ptr_nxt;
    logic [HOLD_W-1:0]    r_hold,  w_hold_nxt;
    logic [TIMER_W-1:0]   r_timer, w_timer_nxt;

    logic                 w_owner_req;
    logic [NUM_PORTS-1:0] w_others;
    logic                 w_any_other;
    logic [IDX_W-1:0]     w_ptr_after;
    logic [NUM_PORTS-1:0] w_pick_req;
    logic [IDX_W-1:0]     w_pick_ptr;
    logic                 w_pick_valid;
    logic [IDX_W-1:0]     w_pick_idx;
    logic [NUM_PORTS-1:0] w_pick_oh;
    logic                 w_release;
    logic                 w_timeout;

    always_comb begin
        w_owner_req = |(req_i & r_grant);
        w_others    = req_i & ~r_grant;
        w_any_other = |w_others;
        w_ptr_after = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        // IDLE arbitrates everyone from the stored pointer; a release in
        // WAIT_RESP hands over directly to the next other requester.
        if (r_state == IDLE) begin
            w_pick_req = req_i;
            w_pick_ptr = r_ptr;
        end else begin
            w_pick_req = w_others;
            w_pick_ptr = w_ptr_after;
        end
    end

    read_slave_scheduler_rr_pick_comb #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .i_req    (w_pick_req),
        .i_ptr    (w_pick_ptr),
        .o_valid  (w_pick_valid),
        .o_idx    (w_pick_idx),
        .o_onehot (w_pick_oh)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_timer_nxt = r_timer;
        w_release   = 1'b0;
        w_timeout   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ADDR;
                    w_grant_nxt = w_pick_oh;
                    w_idx_nxt   = w_pick_idx;
                    w_hold_nxt  = '0;
                end
            end

            ADDR: begin
                // A slave grant is only meaningful while the owner still asks.
                if (!w_owner_req) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_idx_nxt   = '0;
                    w_ptr_nxt   = w_ptr_after;
                end else if (slave_gnt_i) begin
                    w_state_nxt = WAIT_RESP;
                    w_timer_nxt = '0;
                end
            end

            WAIT_RESP: begin
                // rvalid is checked first so it wins over a same-cycle expiry.
                if (slave_rvalid_i) begin
                    if (w_owner_req && ((r_hold != HOLD_LAST) || !w_any_other)) begin
                        w_state_nxt = ADDR;
                        if (r_hold != HOLD_LAST) w_hold_nxt = r_hold + HOLD_W'(1);
                    end else begin
                        w_release = 1'b1;
                    end
                end else if (r_timer == TIMER_LAST) begin
                    w_timeout = 1'b1;
                    w_release = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end

                if (w_release) begin
                    w_ptr_nxt  = w_ptr_after;
                    w_hold_nxt = '0;
                    if (w_pick_valid) begin
                        w_state_nxt = ADDR;
                        w_grant_nxt = w_pick_oh;
                        w_idx_nxt   = w_pick_idx;
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_idx_nxt   = '0;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    assign grant_o     = r_grant;
    assign grant_idx_o = r_idx;
    assign active_o    = |r_grant;
    assign timeout_o   = w_timeout;

endmodule

// File: tb/tb_read_slave_scheduler.sv
// -----------------------------------------------------------------------------
// tb_read_slave_scheduler
//   Self-checking bench for read_slave_scheduler (NUM_PORTS=2, MAX_HOLD=4,
//   TIMEOUT=16). Each slot drives inputs right after a clock edge, pushes the
//   expected grant/timeout for that slot, then pops and compares.
// -----------------------------------------------------------------------------
module tb_read_slave_scheduler;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [1:0] req_i  = 2'b00;
    logic       gnt    = 1'b0;
    logic       rv     = 1'b0;
    logic [1:0] grant;
    logic [0:0] gidx;
    logic       active;
    logic       tout;

    typedef struct {
        logic [1:0] req;
        logic       gnt;
        logic       rv;
        logic [1:0] g;
        logic       t;
    } step_t;

    typedef struct {
        logic [1:0] g;
        logic       t;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    read_slave_scheduler #(
        .NUM_PORTS (2),
        .MAX_HOLD  (4),
        .TIMEOUT   (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_i          (req_i),
        .slave_gnt_i    (gnt),
        .slave_rvalid_i (rv),
        .grant_o        (grant),
        .grant_idx_o    (gidx),
        .active_o       (active),
        .timeout_o      (tout)
    );

    function automatic step_t st(logic [1:0] r, logic g_in, logic v, logic [1:0] g, logic t);
        step_t s;
        s.req = r; s.gnt = g_in; s.rv = v; s.g = g; s.t = t;
        return s;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives one slot's inputs and records what the DUT must show in it.
    task automatic drive(input step_t s);
        req_i = s.req;
        gnt   = s.gnt;
        rv    = s.rv;
        exp_q.push_back('{g: s.g, t: s.t});
        #1;
    endtask

    task automatic apply_reset();
        req_i = 2'b00; gnt = 1'b0; rv = 1'b0;
        exp_q.delete();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset grant: got %b want 00", grant); end
        n_cmp++; if (gidx !== 1'b0)   begin n_err++; $display("FAIL reset grant_idx: got %b want 0", gidx); end
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL reset active: got %b want 0", active); end
        n_cmp++; if (tout !== 1'b0)   begin n_err++; $display("FAIL reset timeout: got %b want 0", tout); end
    endtask

    task automatic test_single();
        step_t seq[$];
        exp_t  e;
        apply_reset();
        seq.push_back(st(2'b01, 0, 0, 2'b00, 0));
        seq.push_back(st(2'b01, 0, 0, 2'b01, 0));
        seq.push_back(st(2'b01, 1, 0, 2'b01, 0));
        seq.push_back(st(2'b00, 0, 1, 2'b01, 0));
        seq.push_back(st(2'b00, 0, 0, 2'b00, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            e = exp_q.pop_front();
            n_cmp++; if ({grant, tout} !== {e.g, e.t}) begin n_err++; $display("FAIL single[%0d] grant/timeout: got %b/%b want %b/%b", i, grant, tout, e.g, e.t); end
            n_cmp++; if (active !== (|e.g)) begin n_err++; $display("FAIL single[%0d] active: got %b want %b", i, active, |e.g); end
            if (e.g != 2'b00) begin n_cmp++; if (gidx !== e.g[1]) begin n_err++; $display("FAIL single[%0d] grant_idx: got %b want %b", i, gidx, e.g[1]); end end
            cyc();
        end
    endtask

    task automatic test_contention();
        step_t      seq[$];
        exp_t       e;
        logic [1:0] oh;
        apply_reset();
        seq.push_back(st(2'b11, 0, 0, 2'b00, 0));
        for (int t = 0; t < 16; t++) begin
            oh = ((t / 4) % 2 == 1) ? 2'b10 : 2'b01;
            seq.push_back(st(2'b11, 1, 0, oh, 0));
            seq.push_back(st(2'b11, 0, 1, oh, 0));
        end
        foreach (seq[i]) begin
            drive(seq[i]);
            e = exp_q.pop_front();
            n_cmp++; if ({grant, tout} !== {e.g, e.t}) begin n_err++; $display("FAIL contention[%0d] grant/timeout: got %b/%b want %b/%b", i, grant, tout, e.g, e.t); end
            if (e.g != 2'b00) begin n_cmp++; if (gidx !== e.g[1]) begin n_err++; $display("FAIL contention[%0d] grant_idx: got %b want %b", i, gidx, e.g[1]); end end
            cyc();
        end
    endtask

    task automatic test_sole_hold();
        step_t seq[$];
        exp_t  e;
        apply_reset();
        seq.push_back(st(2'b01, 0, 0, 2'b00, 0));
        for (int t = 0; t < 6; t++) begin
            seq.push_back(st(2'b01, 1, 0, 2'b01, 0));
            seq.push_back(st(2'b01, 0, 1, 2'b01, 0));
        end
        // Hold is saturated: once master 1 shows up, this transaction is the last.
        seq.push_back(st(2'b11, 1, 0, 2'b01, 0));
        seq.push_back(st(2'b11, 0, 1, 2'b01, 0));
        seq.push_back(st(2'b11, 0, 0, 2'b10, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            e = exp_q.pop_front();
            n_cmp++; if ({grant, tout} !== {e.g, e.t}) begin n_err++; $display("FAIL sole_hold[%0d] grant/timeout: got %b/%b want %b/%b", i, grant, tout, e.g, e.t); end
            cyc();
        end
    endtask

    task automatic test_timeout();
        step_t seq[$];
        exp_t  e;
        apply_reset();
        seq.push_back(st(2'b11, 0, 0, 2'b00, 0));
        seq.push_back(st(2'b11, 1, 0, 2'b01, 0));
        for (int k = 1; k <= 16; k++)
            seq.push_back(st(2'b11, 0, 0, 2'b01, (k == 16) ? 1'b1 : 1'b0));
        seq.push_back(st(2'b11, 0, 1, 2'b10, 0));  // late rvalid, must be ignored
        seq.push_back(st(2'b11, 0, 0, 2'b10, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            e = exp_q.pop_front();
            n_cmp++; if ({grant, tout} !== {e.g, e.t}) begin n_err++; $display("FAIL timeout[%0d] grant/timeout: got %b/%b want %b/%b", i, grant, tout, e.g, e.t); end
            cyc();
        end
    endtask

    task automatic test_rvalid_beats_timeout();
        step_t seq[$];
        exp_t  e;
        apply_reset();
        seq.push_back(st(2'b01, 0, 0, 2'b00, 0));
        seq.push_back(st(2'b01, 1, 0, 2'b01, 0));
        for (int k = 1; k <= 15; k++)
            seq.push_back(st(2'b01, 0, 0, 2'b01, 0));
        seq.push_back(st(2'b01, 0, 1, 2'b01, 0));  // rvalid on the expiry cycle
        seq.push_back(st(2'b01, 0, 0, 2'b01, 0));
        seq.push_back(st(2'b01, 0, 0, 2'b01, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            e = exp_q.pop_front();
            n_cmp++; if ({grant, tout} !== {e.g, e.t}) begin n_err++; $display("FAIL rv_vs_timeout[%0d] grant/timeout: got %b/%b want %b/%b", i, grant, tout, e.g, e.t); end
            cyc();
        end
    endtask

    task automatic test_withdraw();
        step_t seq[$];
        exp_t  e;
        apply_reset();
        seq.push_back(st(2'b11, 0, 0, 2'b00, 0));
        seq.push_back(st(2'b11, 0, 0, 2'b01, 0));
        seq.push_back(st(2'b10, 0, 0, 2'b01, 0));
        seq.push_back(st(2'b10, 0, 1, 2'b00, 0));  // rvalid in IDLE is ignored
        seq.push_back(st(2'b10, 0, 0, 2'b10, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            e = exp_q.pop_front();
            n_cmp++; if ({grant, tout} !== {e.g, e.t}) begin n_err++; $display("FAIL withdraw[%0d] grant/timeout: got %b/%b want %b/%b", i, grant, tout, e.g, e.t); end
            cyc();
        end
    endtask

    task automatic test_async_reset();
        step_t seq[$];
        exp_t  e;
        apply_reset();
        seq.push_back(st(2'b01, 0, 0, 2'b00, 0));
        seq.push_back(st(2'b00, 0, 0, 2'b01, 0));  // master 0 drops: ptr moves to 1
        seq.push_back(st(2'b10, 0, 0, 2'b00, 0));
        seq.push_back(st(2'b10, 1, 0, 2'b10, 0));
        seq.push_back(st(2'b10, 0, 0, 2'b10, 0));  // in WAIT_RESP
        foreach (seq[i]) begin
            drive(seq[i]);
            e = exp_q.pop_front();
            n_cmp++; if ({grant, tout} !== {e.g, e.t}) begin n_err++; $display("FAIL async_rst[%0d] grant/timeout: got %b/%b want %b/%b", i, grant, tout, e.g, e.t); end
            if (i < seq.size() - 1) cyc();
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL async_rst grant: got %b want 00", grant); end
        n_cmp++; if (gidx !== 1'b0)   begin n_err++; $display("FAIL async_rst grant_idx: got %b want 0", gidx); end
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL async_rst active: got %b want 0", active); end
        req_i = 2'b11; gnt = 1'b0; rv = 1'b1;
        @(posedge clk);
        #3 reset = 1'b1; rv = 1'b0;
        cyc();
        exp_q.push_back('{g: 2'b01, t: 1'b0});
        e = exp_q.pop_front();
        n_cmp++; if (grant !== e.g) begin n_err++; $display("FAIL async_rst first grant after release: got %b want %b", grant, e.g); end
        n_cmp++; if (gidx !== e.g[1]) begin n_err++; $display("FAIL async_rst grant_idx after release: got %b want %b", gidx, e.g[1]); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_sole_hold();
        test_timeout();
        test_rvalid_beats_timeout();
        test_withdraw();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
